// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Pipelined bitwise logic / shift unit with a valid/ready handshake on both
// sides. The result and its zero flag are computed combinationally from the
// accepted operands and then carried through PIPE_STAGES elastic register
// stages. Each stage has its own valid bit and holds its contents when the
// stage downstream is full and stalled.
//
// Parameters
//   DATA_WIDTH  : operand/result width (power of two, 4..64)
//   PIPE_STAGES : number of result register stages (1..4)
//
// Ports
//   CLK        in   clock, all state on rising edge
//   RST        in   asynchronous active-low reset
//   A, B       in   operands; B[log2(DATA_WIDTH)-1:0] is the shift amount
//   ALU_FUNC   in   operation select
//   IN_VALID   in   A/B/ALU_FUNC valid
//   IN_READY   out  an operation can be accepted this cycle
//   Logic_OUT  out  result (0 when Logic_Flag=0)
//   Logic_Flag out  Logic_OUT valid
//   Zero_Flag  out  Logic_OUT == 0, qualified by Logic_Flag
//   OUT_READY  in   downstream accepts the result
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
    parameter int DATA_WIDTH  = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALU_FUNC,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [DATA_WIDTH-1:0] Logic_OUT,
    output logic                  Logic_Flag,
    output logic                  Zero_Flag,
    input  logic                  OUT_READY
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [SH_W-1:0]       w_shamt;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_zero;
    logic [PIPE_STAGES:0]  w_ready;   // w_ready[k]: stage k may load this cycle

    logic                  r_valid [PIPE_STAGES];
    logic [DATA_WIDTH-1:0] r_data  [PIPE_STAGES];
    logic                  r_zero  [PIPE_STAGES];

    // Only the low log2(DATA_WIDTH) bits of B select the shift distance.
    assign w_shamt = B[SH_W-1:0];

    always_comb begin
        w_result = '0;
        case (ALU_FUNC)
            3'b000:  w_result = A & B;
            3'b001:  w_result = A | B;
            3'b010:  w_result = ~(A & B);
            3'b011:  w_result = ~(A | B);
            3'b100:  w_result = A ^ B;
            3'b101:  w_result = ~(A ^ B);
            3'b110:  w_result = A << w_shamt;
            default: w_result = A >> w_shamt;
        endcase
    end

    assign w_zero = (w_result == '0);

    // Ready ripples backwards from the output: a stage can load when it is
    // empty or when its own contents leave in the same cycle. This gives a
    // fully elastic pipeline with no bubble when a stall is released.
    always_comb begin
        w_ready = '0;
        w_ready[PIPE_STAGES] = OUT_READY;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            w_ready[k] = !r_valid[k] || w_ready[k+1];
        end
    end

    // Stages that load an empty slot also clear their data and zero flag, so
    // the output stage presents 0/0 whenever it holds no valid result.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_zero[k]  <= 1'b0;
            end
        end else begin
            if (w_ready[0]) begin
                r_valid[0] <= IN_VALID;
                r_data[0]  <= IN_VALID ? w_result : '0;
                r_zero[0]  <= IN_VALID && w_zero;
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    r_data[k]  <= r_data[k-1];
                    r_zero[k]  <= r_zero[k-1];
                end
            end
        end
    end

    // While reset is asserted the stages are empty, so the ready chain alone
    // would report ready; gate it with RST so nothing is offered as taken.
    assign IN_READY   = RST && w_ready[0];

    assign Logic_OUT  = r_data[PIPE_STAGES-1];
    assign Logic_Flag = r_valid[PIPE_STAGES-1];
    assign Zero_Flag  = r_zero[PIPE_STAGES-1];

endmodule
